// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C memory slave front-end.
// Pure declarations; no logic, no latency, no flow control.
package i2c_pkg;
    localparam int MEM_AW = 7;
    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        MEM_ADDR,
        MADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with one history flop; emits SCL edge pulses and START/STOP pulses.
// Pulses appear SYNC_STAGES+1 CLK after the pad edge; no backpressure (free-running sampler).
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl;
    logic                   scl_high;
    logic                   sda_rise;
    logic                   sda_fall;

    // Lines idle high, so reset the chains to 1 to avoid a false edge after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl;
            sda_hist <= sda;
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_hist;
    assign scl_fall  = ~scl & scl_hist;
    assign sda_rise  = sda & ~sda_hist;
    assign sda_fall  = ~sda & sda_hist;
    assign scl_high  = scl & scl_hist;
    assign start_det = sda_fall & scl_high;
    assign stop_det  = sda_rise & scl_high;
endmodule

// File: rtl/i2c_mem_slave_ctrl.sv
// I2C slave front-end for the 128x8 register memory: byte framing, ACKs, auto-incrementing word pointer.
// Write strobe 1 CLK after the synchronized 8th scl_rise; SCL is never stretched, so no backpressure.
module i2c_mem_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [MEM_AW-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [3:0] BYTE_BITS = 4'd8;

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] rx_byte;
    logic [DATA_W-1:0] wdata_d;
    logic [3:0]        bit_cnt;
    logic [3:0]        bit_cnt_d;
    logic [MEM_AW-1:0] ptr;
    logic [MEM_AW-1:0] ptr_d;
    logic              sda_oe_d;
    logic              wr_d;
    logic              busy_d;
    logic              sda;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .CLK      (CLK),
        .RST      (RST),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign rx_byte = {shift[DATA_W-2:0], sda};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // mem_addr trails ptr by one cycle, so the strobe cycle still carries the pre-increment address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift     <= '0;
            bit_cnt   <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            shift     <= shift_d;
            bit_cnt   <= bit_cnt_d;
            ptr       <= ptr_d;
            sda_oe    <= sda_oe_d;
            mem_addr  <= ptr;
            mem_wdata <= wdata_d;
            mem_rw_en <= wr_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        ptr_d     = ptr;
        sda_oe_d  = sda_oe;
        wdata_d   = mem_wdata;
        wr_d      = 1'b0;
        busy_d    = busy;

        if (mem_rw_en) begin
            ptr_d = ptr + MEM_AW'(1);
        end

        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = DEV_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state)
                DEV_ADDR, MEM_ADDR, WR_DATA: begin
                    if (scl_rise && bit_cnt != BYTE_BITS) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt + 4'd1;
                        if (bit_cnt == BYTE_BITS - 4'd1) begin
                            if (state == MEM_ADDR) begin
                                ptr_d = rx_byte[MEM_AW-1:0];
                            end
                            if (state == WR_DATA) begin
                                wr_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                        end
                    end else if (scl_fall && bit_cnt == BYTE_BITS) begin
                        bit_cnt_d = '0;
                        if (state == DEV_ADDR && shift[DATA_W-1:1] != SLAVE_ADDR) begin
                            state_d = IGNORE;
                        end else begin
                            sda_oe_d = 1'b1;
                            busy_d   = busy | (state == DEV_ADDR);
                            state_d  = (state == DEV_ADDR) ? DEV_ACK :
                                       (state == MEM_ADDR) ? MADDR_ACK : WR_ACK;
                        end
                    end
                end
                DEV_ACK, MADDR_ACK, WR_ACK: begin
                    // shift[0] still holds the R/W bit of the device address byte.
                    if (scl_fall) begin
                        if (state == DEV_ACK && shift[0]) begin
                            shift_d  = mem_rdata;
                            sda_oe_d = ~mem_rdata[DATA_W-1];
                            state_d  = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = (state == DEV_ACK) ? MEM_ADDR : WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == BYTE_BITS) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d  = {shift[DATA_W-2:0], 1'b0};
                            sda_oe_d = ~shift[DATA_W-2];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr + MEM_AW'(1);
                        end
                    end else if (scl_fall) begin
                        shift_d  = mem_rdata;
                        sda_oe_d = ~mem_rdata[DATA_W-1];
                        state_d  = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_mem_slave_ctrl.sv
// Bit-banged I2C master plus 128x8 memory around i2c_mem_slave_ctrl, checked against a byte-level model.
module tb_i2c_mem_slave_ctrl;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       mem_rw_en;
    logic       busy;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0]  mem [128];
    logic [7:0]  model_mem [128];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [7:0]  pl_data = '0;
    logic [14:0] got_q [$];
    logic [14:0] exp_q [$];
    logic [7:0]  wq [$];
    int          checks = 0;
    int          errors = 0;
    int          oe_cycles = 0;
    int          strobes = 0;
    int          double_strobes = 0;
    logic        prev_wr = 1'b0;
    int          mptr = 0;
    int          oe0;
    int          st0;
    logic        ack;
    logic [7:0]  d;

    assign sda_line = sda_m & ~sda_oe;

    i2c_mem_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rw_en(mem_rw_en),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_rw_en) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge CLK) begin
        if (sda_oe) oe_cycles++;
        if (mem_rw_en) begin
            strobes++;
            got_q.push_back({mem_addr, mem_wdata});
            if (prev_wr) double_strobes++;
        end
        prev_wr = mem_rw_en;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: no summary within cycle budget, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] v);
        pl_addr = a; pl_data = v; pl_en = 1'b1;
        tick(1);
        pl_en = 1'b0;
        model_mem[a] = v;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic a);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(b);
        a = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic a);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~a);
    endtask

    task automatic compare_writes(input string tag);
        tick(2);
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // Byte-level model: the address byte sets the pointer, each data byte lands at the pointer then bumps it mod 128.
    task automatic do_write(input string tag, input logic [7:0] abyte, input logic [7:0] data [$]);
        logic a;
        bus_start();
        send_byte(8'hA0, a);
        check({tag, "_dev_ack"}, a, 1);
        check({tag, "_busy"}, busy, 1);
        send_byte(abyte, a);
        check({tag, "_addr_ack"}, a, 1);
        mptr = int'(abyte[6:0]);
        foreach (data[i]) begin
            send_byte(data[i], a);
            check({tag, "_data_ack"}, a, 1);
            exp_q.push_back({7'(mptr), data[i]});
            model_mem[mptr] = data[i];
            mptr = (mptr + 1) % 128;
        end
        bus_stop();
        tick(4);
        check({tag, "_busy_after_stop"}, busy, 0);
        compare_writes(tag);
    endtask

    task automatic do_read(input string tag, input logic [6:0] a7, input int n);
        logic       a;
        logic [7:0] v;
        bus_start();
        send_byte(8'hA0, a);
        check({tag, "_dev_ack"}, a, 1);
        send_byte({1'b0, a7}, a);
        check({tag, "_addr_ack"}, a, 1);
        bus_start();
        send_byte(8'hA1, a);
        check({tag, "_rd_dev_ack"}, a, 1);
        mptr = int'(a7);
        for (int i = 0; i < n; i++) begin
            recv_byte(v, i < n - 1);
            check({tag, "_rd_data"}, v, model_mem[mptr]);
            if (i < n - 1) mptr = (mptr + 1) % 128;
        end
        bus_stop();
        tick(4);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) preload(7'(i), 8'($urandom));
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rw_en", mem_rw_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dut.state, IDLE);
        RST = 1'b0;
        tick(4);

        // Single write.
        wq.delete(); wq.push_back(8'h3C);
        do_write("single", 8'h05, wq);

        // Burst with pointer wrap.
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        do_write("wrap", 8'h7E, wq);

        // Random read through repeated START.
        preload(7'd9, 8'hA5);
        preload(7'd10, 8'h5A);
        st0 = strobes;
        do_read("rdrs", 7'd9, 2);
        check("rdrs_no_strobe", strobes - st0, 0);

        // Foreign device address.
        oe0 = oe_cycles;
        bus_start();
        send_byte(8'hA2, ack);
        check("mm_dev_ack", ack, 0);
        check("mm_busy", busy, 0);
        send_byte(8'h05, ack);
        check("mm_addr_ack", ack, 0);
        send_byte(8'hFF, ack);
        check("mm_data_ack", ack, 0);
        bus_stop();
        tick(4);
        check("mm_oe_cycles", oe_cycles - oe0, 0);
        check("mm_busy_end", busy, 0);
        compare_writes("mm");

        // Reset after 4 data bits of a write.
        bus_start();
        send_byte(8'hA0, ack);
        check("rstmid_dev_ack", ack, 1);
        send_byte(8'h20, ack);
        check("rstmid_addr_ack", ack, 1);
        for (int i = 7; i >= 4; i--) put_bit(d[i] ^ 1'b1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("rstmid_sda_oe", sda_oe, 0);
        check("rstmid_state", dut.state, IDLE);
        check("rstmid_busy", busy, 0);
        bus_stop();
        compare_writes("rstmid");
        wq.delete(); wq.push_back(8'h99);
        do_write("after_rst", 8'h20, wq);

        // STOP after 3 data bits: no write, pointer keeps the address byte value.
        bus_start();
        send_byte(8'hA0, ack);
        check("stopmid_dev_ack", ack, 1);
        send_byte(8'h33, ack);
        check("stopmid_addr_ack", ack, 1);
        mptr = 'h33;
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        bus_stop();
        tick(4);
        check("stopmid_state", dut.state, IDLE);
        compare_writes("stopmid");
        bus_start();
        send_byte(8'hA1, ack);
        check("curread_ack", ack, 1);
        recv_byte(d, 1'b0);
        check("curread_data", d, model_mem[mptr]);
        bus_stop();
        tick(4);

        // Randomized bursts, each read back through the model.
        for (int it = 0; it < 4; it++) begin
            logic [6:0] a7;
            int         len;
            a7  = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 4);
            wq.delete();
            for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
            do_write("rnd", {1'($urandom_range(0, 1)), a7}, wq);
            do_read("rnd", a7, len);
        end

        check("double_strobe", double_strobes, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_mem_slave_ctrl.md
Name: i2c_mem_slave_ctrl

Overview:
- I2C slave front-end that sits directly upstream of the 128x8 register memory.
- Oversamples SCL/SDA on the system clock, decodes START, STOP, address, ACK and data phases, and converts serial transactions into single-cycle memory writes and registered memory reads.
- A 7-bit word pointer is set by the first data byte after the device address, and auto-increments on every data byte.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit I2C device address this block responds to.
- SYNC_STAGES, 2, number of synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- CLK  input  1  system clock; must be at least 16x the SCL frequency.
- RST  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL from pad.
- sda_in  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- mem_addr  output  7  memory address, drives memory addr.
- mem_wdata  output  8  write data, drives memory data.
- mem_rw_en  output  1  one-cycle write strobe, drives memory RW_EN; 0 means read.
- mem_rdata  input  8  memory data_read; valid 1 CLK after mem_addr is stable with mem_rw_en=0.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset (sync, RST=1 at posedge CLK):
  - state=IDLE; sda_oe=0, mem_rw_en=0, mem_addr=0, mem_wdata=0, busy=0.
  - Word pointer=0, bit counter=0, shift register=0, synchronizers=1.
  - Reset mid-transaction releases SDA on the next edge and drops any pending write.
- Sampling: SCL/SDA pass through SYNC_STAGES flops plus one history flop.
  - scl_rise/scl_fall/sda_rise/sda_fall are one-cycle pulses derived from the synchronized values.
- Bus events:
  - START = sda_fall while SCL high.
  - STOP = sda_rise while SCL high.
  - START/STOP take priority over data handling in every state.
  - A repeated START enters DEV_ADDR from any state.
  - STOP returns to IDLE from any state.
- Data timing:
  - Receive bits shift in MSB first on scl_rise.
  - sda_oe changes only on scl_fall (1 CLK after the pulse).
- States:
  - IDLE: wait for START -> DEV_ADDR.
  - DEV_ADDR: shift 8 bits.
    - Upper 7 bits == SLAVE_ADDR -> DEV_ACK, busy=1.
    - Otherwise -> IGNORE (sda_oe=0 until STOP/START).
  - DEV_ACK: drive ACK for one SCL period.
    - R/W=0 -> MEM_ADDR.
    - R/W=1 -> RD_DATA; mem_addr=pointer during ACK, and the shift register loads mem_rdata on the scl_fall that ends ACK.
  - MEM_ADDR: shift 8 bits; pointer = byte[6:0] (bit 7 ignored) -> MADDR_ACK (ACK) -> WR_DATA.
  - WR_DATA: after the 8th scl_rise, assert mem_rw_en for exactly 1 CLK with mem_addr=pointer and mem_wdata=byte; pointer++ next cycle -> WR_ACK (ACK) -> WR_DATA.
  - RD_DATA: drive sda_oe = ~shift[7] per bit -> RD_ACK; sda_oe=0 and sample master ACK on scl_rise.
    - ACK (SDA=0): pointer++, mem_addr=pointer; load the next byte on scl_fall -> RD_DATA.
    - NACK: -> IGNORE.
- Pointer wrap: 7'h7F + 1 = 7'h00, in both read and write.
- mem_rw_en is never high outside WR_DATA completion; it is never high for two consecutive cycles.
- Latency:
  - Write strobe occurs 1 CLK after the synchronized 8th scl_rise (SYNC_STAGES+2 CLK after the pad edge).
  - Read data is fetched at least 8 CLK before it is needed.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE).
  - MEM_AW=7 and DATA_W=8 constants.
- Sub-module i2c_line_sync: synchronizers plus edge and START/STOP detection, instantiated once for the SCL/SDA pair.

Test Plan:
- Single write: START, 0xA0, 0x05, 0x3C, STOP -> three ACKs; one mem_rw_en pulse with mem_addr=5, mem_wdata=0x3C; busy falls after STOP.
- Burst write with wrap: START, 0xA0, 0x7E, 0x11, 0x22, 0x33 -> writes at 0x7E=0x11, 0x7F=0x22, 0x00=0x33.
- Random read via repeated START: preload mem[9]=0xA5, mem[10]=0x5A; START, 0xA0, 0x09, rSTART, 0xA1, master ACK, then NACK -> SDA bytes 0xA5, 0x5A; no mem_rw_en pulses.
- Address mismatch: START, 0xA2, 0x05, 0xFF, STOP -> sda_oe stays 0 throughout, no writes, busy=0.
- Reset mid-byte: assert RST for 1 CLK after the 4th data bit of a write -> sda_oe=0 and state=IDLE next cycle; no write strobe; a following valid transaction completes normally.
- STOP mid-byte: STOP after 3 data bits -> no write; pointer unchanged; state=IDLE.
